mem_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port block RAM among `NUM_REQ` requesters. It accepts one request per transaction, sequences the memory enable and write-enable strobes, and returns read data to the requester that issued the read. It sits between the memory clients and the BRAM instance, and is the only driver of the BRAM control, address and data inputs.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the block-RAM round-robin arbiter.
// Holds the FSM state encoding and the index-width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RDATA = 2'd3
    } state_t;

    // Width of a requester index; never below one bit.
    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ. Returns one-hot grant, binary index and a valid flag.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr is always below NUM_REQ, so a single subtraction wraps
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            cand = sum[IDX_W-1:0];
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM among NUM_REQ requesters.
// One transaction at a time: grant in IDLE, then a WRITE strobe or a READ + RDATA pair.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               rvalid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             busy_o,
    output logic                             mem_en_o,
    output logic                             mem_we_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [DATA_WIDTH-1:0]            mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] winner_q;
    logic             we_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   win_idx;
    logic               arb_valid;
    logic               take;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_arr[k]  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[k] = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req   (req_i),
        .ptr   (rr_ptr_q),
        .gnt   (arb_gnt),
        .idx   (win_idx),
        .valid (arb_valid)
    );

    // A grant is only issued from IDLE and never while reset is held
    assign take = (state_q == IDLE) && arb_valid && rst_ni;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_o    = '0;
        rvalid_o = '0;
        mem_en_o = 1'b0;
        mem_we_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (take) begin
                    gnt_o   = arb_gnt;
                    state_d = we_i[win_idx] ? WRITE : READ;
                end
            end
            WRITE: begin
                mem_en_o = 1'b1;
                mem_we_o = we_q;
                state_d  = IDLE;
            end
            READ: begin
                mem_en_o = 1'b1;
                state_d  = RDATA;
            end
            RDATA: begin
                rvalid_o[winner_q] = 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture registers; mem_addr_o/mem_wdata_o hold their value between grants
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            we_q        <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else if (take) begin
            winner_q    <= win_idx;
            we_q        <= we_i[win_idx];
            mem_addr_o  <= addr_arr[win_idx];
            mem_wdata_o <= wdata_arr[win_idx];
            if (win_idx == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr_q <= '0;
            end else begin
                rr_ptr_q <= win_idx + 1'b1;
            end
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// sequences for write/read-back, fairness, pointer skip, mixed traffic and reset aborts.
module tb_mem_arbiter;

    logic         clk_i;
    logic         rst_ni;
    logic [3:0]   req_i;
    logic [3:0]   we_i;
    logic [39:0]  addr_i;
    logic [127:0] wdata_i;
    logic [3:0]   gnt_o;
    logic [3:0]   rvalid_o;
    logic [31:0]  rdata_o;
    logic         busy_o;
    logic         mem_en_o;
    logic         mem_we_o;
    logic [9:0]   mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic [31:0]  mem_rdata_i;

    int n_pass  = 0;
    int n_total = 0;

    mem_arbiter #(
        .NUM_REQ    (4),
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // BRAM model: one-cycle read latency, preloaded with 0x1000_0000 + address
    logic [31:0] mem [1024];
    logic        mem_ready = 1'b0;

    always @(posedge clk_i) begin
        if (!mem_ready) begin
            for (int a = 0; a < 1024; a++) begin
                mem[a] <= 32'h1000_0000 + 32'(a);
            end
            mem_ready <= 1'b1;
        end else if (mem_en_o) begin
            if (mem_we_o) begin
                mem[mem_addr_o] <= mem_wdata_o;
            end else begin
                mem_rdata_i <= mem[mem_addr_o];
            end
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic [3:0]  gnt;
        logic [3:0]  rvalid;
        logic        busy;
        logic        en;
        logic        wen;
        logic [9:0]  addr;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_slot(input int k, input logic [9:0] a, input logic [31:0] d);
        addr_i[k*10 +: 10]  = a;
        wdata_i[k*32 +: 32] = d;
    endtask

    task automatic reset_pulse();
        req_i  = 4'b0000;
        we_i   = 4'b0000;
        rst_ni = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g;
        logic [3:0] exp_v;

        rst_ni  = 1'b0;
        req_i   = 4'b1111;
        we_i    = 4'b0000;
        addr_i  = '0;
        wdata_i = '0;
        next_cycle();

        // Reset held with every requester asking: nothing may be granted
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("rst_gnt", 32'(gnt_o), 32'h0);
            check("rst_busy", 32'(busy_o), 32'h0);
            check("rst_en", 32'(mem_en_o), 32'h0);
            next_cycle();
        end
        rst_ni = 1'b1;
        req_i  = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            check("idle_outs", 32'({gnt_o, rvalid_o, busy_o, mem_en_o, mem_we_o}), 32'h0);
            next_cycle();
        end
        check("idle_addr", 32'(mem_addr_o), 32'h0);
        check("idle_wdata", mem_wdata_o, 32'h0);

        // Vector table, starting from rr_ptr = 0
        for (int k = 0; k < 4; k++) begin
            set_slot(k, 10'(10'h10 + k), 32'hC0DE_0000 + 32'(k));
        end
        vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 10'h000, 32'h0};
        vecs[1] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 10'h000, 32'h0};
        vecs[2] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 10'h011, 32'h0};
        vecs[3] = '{4'b1001, 4'b0001, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 10'h011, 32'h0};
        vecs[4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 10'h013, 32'h0};
        vecs[5] = '{4'b0001, 4'b0001, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0, 10'h013, 32'h1000_0013};
        vecs[6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 10'h013, 32'h0};
        vecs[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 10'h010, 32'h0};
        vecs[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 10'h010, 32'h0};
        for (int v = 0; v < 9; v++) begin
            req_i = vecs[v].req;
            we_i  = vecs[v].we;
            @(negedge clk_i);
            check($sformatf("vec%0d_gnt", v), 32'(gnt_o), 32'(vecs[v].gnt));
            check($sformatf("vec%0d_rvalid", v), 32'(rvalid_o), 32'(vecs[v].rvalid));
            check($sformatf("vec%0d_busy", v), 32'(busy_o), 32'(vecs[v].busy));
            check($sformatf("vec%0d_en_we", v), 32'({mem_en_o, mem_we_o}), 32'({vecs[v].en, vecs[v].wen}));
            check($sformatf("vec%0d_addr", v), 32'(mem_addr_o), 32'(vecs[v].addr));
            if (vecs[v].rvalid != 4'b0000) begin
                check($sformatf("vec%0d_rdata", v), rdata_o, vecs[v].rdata);
            end
            next_cycle();
        end

        // Requester 1 writes 0xDEADBEEF to 0x05, then reads it back
        set_slot(1, 10'h005, 32'hDEAD_BEEF);
        req_i = 4'b0010;
        we_i  = 4'b0010;
        @(negedge clk_i);
        check("wr_gnt", 32'(gnt_o), 32'h2);
        next_cycle();
        req_i = 4'b0000;
        we_i  = 4'b0000;
        @(negedge clk_i);
        check("wr_en_we", 32'({mem_en_o, mem_we_o}), 32'h3);
        check("wr_addr", 32'(mem_addr_o), 32'h005);
        check("wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        next_cycle();
        req_i = 4'b0010;
        @(negedge clk_i);
        check("rd_gnt", 32'(gnt_o), 32'h2);
        next_cycle();
        req_i = 4'b0000;
        @(negedge clk_i);
        check("rd_en_we", 32'({mem_en_o, mem_we_o}), 32'h2);
        next_cycle();
        @(negedge clk_i);
        check("rd_rvalid", 32'(rvalid_o), 32'h2);
        check("rd_rdata", rdata_o, 32'hDEAD_BEEF);
        next_cycle();
        @(negedge clk_i);
        check("rd_rvalid_end", 32'(rvalid_o), 32'h0);
        next_cycle();

        // Fairness: all four reading continuously, grants every third cycle in order
        for (int k = 0; k < 4; k++) begin
            set_slot(k, 10'(10'h10 + k), 32'h0);
        end
        reset_pulse();
        req_i = 4'b1111;
        we_i  = 4'b0000;
        for (int c = 0; c < 36; c++) begin
            exp_g = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
            exp_v = (c % 3 == 2) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
            @(negedge clk_i);
            check($sformatf("rr_gnt_c%0d", c), 32'(gnt_o), 32'(exp_g));
            check($sformatf("rr_rvalid_c%0d", c), 32'(rvalid_o), 32'(exp_v));
            next_cycle();
        end
        req_i = 4'b0000;

        // Pointer skip: after granting requester 1, rr_ptr is 2; 0011 then goes to 0
        req_i = 4'b0010;
        we_i  = 4'b0010;
        @(negedge clk_i);
        check("skip_setup_gnt", 32'(gnt_o), 32'h2);
        next_cycle();
        req_i = 4'b0000;
        we_i  = 4'b0000;
        next_cycle();
        req_i = 4'b0011;
        @(negedge clk_i);
        check("skip_gnt0", 32'(gnt_o), 32'h1);
        next_cycle();
        @(negedge clk_i);
        check("skip_read_gnt", 32'(gnt_o), 32'h0);
        next_cycle();
        @(negedge clk_i);
        check("skip_rdata_gnt", 32'(gnt_o), 32'h0);
        check("skip_rvalid", 32'(rvalid_o), 32'h1);
        next_cycle();
        // rr_ptr is now 1, so requester 1 wins over the re-asserted requester 0
        @(negedge clk_i);
        check("skip_gnt1", 32'(gnt_o), 32'h2);
        next_cycle();
        req_i = 4'b0000;
        next_cycle();
        next_cycle();

        // Mixed: req 0 writes 0x20, req 3 reads 0x20 in the same cycle
        reset_pulse();
        set_slot(0, 10'h020, 32'h1234_5678);
        set_slot(3, 10'h020, 32'h0);
        req_i = 4'b1001;
        we_i  = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            case (c)
                0: check("mix_gnt_w", 32'(gnt_o), 32'h1);
                1: check("mix_wr_strobe", 32'({mem_en_o, mem_we_o}), 32'h3);
                2: check("mix_gnt_r", 32'(gnt_o), 32'h8);
                3: check("mix_rd_strobe", 32'({mem_en_o, mem_we_o}), 32'h2);
                4: check("mix_rdata", rdata_o, 32'h1234_5678);
                default: check("mix_idle", 32'(busy_o), 32'h0);
            endcase
            // rvalid only in the RDATA cycle of the read granted two cycles after the write
            check($sformatf("mix_rvalid_c%0d", c), 32'(rvalid_o), (c == 4) ? 32'h8 : 32'h0);
            next_cycle();
            if (c == 0) begin
                req_i = 4'b1000;
                we_i  = 4'b0000;
            end else if (c == 2) begin
                req_i = 4'b0000;
            end
        end

        // Reset during the READ cycle aborts the read and clears rr_ptr
        req_i = 4'b0100;
        we_i  = 4'b0000;
        @(negedge clk_i);
        check("abort_gnt", 32'(gnt_o), 32'h4);
        next_cycle();
        req_i  = 4'b1111;
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("abort_no_gnt", 32'(gnt_o), 32'h0);
        check("abort_rvalid_rd", 32'(rvalid_o), 32'h0);
        next_cycle();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("abort_rvalid", 32'(rvalid_o), 32'h0);
        check("abort_en", 32'(mem_en_o), 32'h0);
        check("abort_ptr_gnt", 32'(gnt_o), 32'h1);
        next_cycle();
        req_i = 4'b0000;
        @(negedge clk_i);
        check("abort_busy", 32'(busy_o), 32'h1);
        next_cycle();
        @(negedge clk_i);
        check("abort_next_rvalid", 32'(rvalid_o), 32'h1);
        next_cycle();
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
